hist_cdf_reader: RTL and testbench

Reads the 64-entry histogram RAM after the histogram controller finishes writing it and pulses start. Reads bins 0..hist_bins in order, one at a time, through the RAM's synchronous read port. Accumulates a running cumulative distribution (CDF) and streams each (bin index, count, CDF) tuple to a downstream consumer, such as the equalization LUT builder, over a valid/ready handshake. Sits between the histogram RAM read port and the equalization stage.

---
 rtl/hist_cdf_reader.sv | 129 ++++++++++++
 tb/tb_hist_cdf_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_cdf_reader.sv
// Walks histogram bins 0..hist_bins through a synchronous-read RAM port and streams (index, count, CDF) tuples.
// Latency: 3 cycles per bin (read, wait, send); the send phase stretches while the consumer withholds ready.
module hist_cdf_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] hist_bins,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_count,
    output logic [DATA_W-1:0] out_cdf,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_last_idx;
    logic [DATA_W-1:0]   r_cdf;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_index;
    logic [DATA_W-1:0]   r_out_count;
    logic [DATA_W-1:0]   r_out_cdf;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;
    logic                w_hs;
    logic                w_at_last;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_cdf_sat;

    assign w_hs      = (r_state == S_SEND) && r_out_valid && out_ready;
    assign w_at_last = (r_idx == r_last_idx);
    assign w_sum     = {1'b0, r_cdf} + {1'b0, rd_data};
    // Once the carry bit is set the CDF pins at all-ones; adding to all-ones keeps it there.
    assign w_cdf_sat = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_READ;
            S_READ: w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_SEND;
            S_SEND: if (w_hs) w_state_nxt = w_at_last ? S_DONE : S_READ;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= '0;
            r_last_idx  <= '0;
            r_cdf       <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_count <= '0;
            r_out_cdf   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en <= (w_state_nxt == S_READ);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            if ((r_state == S_IDLE) && start) begin
                r_last_idx <= hist_bins;
                r_idx      <= '0;
                r_cdf      <= '0;
                r_rd_addr  <= '0;
            end
            if (r_state == S_WAIT) begin
                r_out_count <= rd_data;
                r_out_cdf   <= w_cdf_sat;
                r_cdf       <= w_cdf_sat;
                r_out_index <= r_idx;
                r_out_last  <= w_at_last;
                r_out_valid <= 1'b1;
            end
            if (w_hs) begin
                r_out_valid <= 1'b0;
                if (!w_at_last) begin
                    r_idx     <= r_idx + ADDR_W'(1);
                    r_rd_addr <= r_idx + ADDR_W'(1);
                end
            end
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_count = r_out_count;
    assign out_cdf   = r_out_cdf;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_hist_cdf_reader.sv
// Bench for hist_cdf_reader: RAM model plus a saturating-prefix-sum reference checked on every handshake.
module tb_hist_cdf_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  hist_bins;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic [31:0] out_count;
    logic [31:0] out_cdf;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [64];
    int vectors = 0;
    int errors  = 0;
    int last_hs_cyc;
    int done_cyc;
    logic [31:0] last_cdf;

    hist_cdf_reader #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .hist_bins(hist_bins),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_count(out_count), .out_cdf(out_cdf), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // mode 0: ready always high; 1: ready low 5 cycles per tuple; 2: random ready.
    task automatic run_pass(input int nb, input int mode, input bit spur);
        logic [31:0] exp_cdf [64];
        longint c;
        int k, cyc, ndone, stall;
        bit pv;
        logic [70:0] prev;
        c = 0;
        for (int i = 0; i <= nb; i++) begin
            c = c + longint'(mem[i]);
            if (c > 64'h0000_0000_FFFF_FFFF) c = 64'h0000_0000_FFFF_FFFF;
            exp_cdf[i] = c[31:0];
        end
        @(negedge clk);
        hist_bins = 6'(nb);
        start = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk);
        #1 start = 1'b0;
        hist_bins = 6'($urandom);
        k = 0; cyc = 0; ndone = 0; stall = 0; pv = 0; prev = '0; done_cyc = 0; last_hs_cyc = 0;
        while (cyc < 3000 && !(ndone > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            if (pv && out_valid) begin
                vectors++;
                if ({out_index, out_count, out_cdf, out_last} !== prev) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d got=%h want=%h", cyc,
                             {out_index, out_count, out_cdf, out_last}, prev);
                end
            end
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1 && out_valid) begin
                if (stall < 5) begin out_ready = 1'b0; stall++; end
                else begin out_ready = 1'b1; stall = 0; end
            end else out_ready = 1'($urandom_range(0, 1));
            start = (spur && busy && (done || $urandom_range(0, 3) == 0)) ? 1'b1 : 1'b0;
            if (out_valid && out_ready) begin
                vectors++;
                if (k > nb) begin
                    errors++;
                    $display("FAIL extra_tuple idx=%0d got_count=%0d want_none", out_index, out_count);
                end else if (out_index !== 6'(k) || out_count !== mem[k] ||
                             out_cdf !== exp_cdf[k] || out_last !== (k == nb)) begin
                    errors++;
                    $display("FAIL tuple k=%0d got idx=%0d cnt=%h cdf=%h last=%b want idx=%0d cnt=%h cdf=%h last=%b",
                             k, out_index, out_count, out_cdf, out_last, k, mem[k], exp_cdf[k], (k == nb));
                end
                last_hs_cyc = cyc;
                last_cdf = out_cdf;
                k++;
            end
            vectors++;
            if (rd_en && out_valid) begin
                errors++;
                $display("FAIL rd_en_in_send cyc=%0d got rd_en=1 want 0", cyc);
            end
            if (done) begin ndone++; done_cyc = cyc; end
            pv = out_valid && !out_ready;
            prev = {out_index, out_count, out_cdf, out_last};
        end
        start = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (k !== nb + 1) begin
            errors++;
            $display("FAIL tuple_count got=%0d want=%0d", k, nb + 1);
        end
        vectors++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL done_pulses got=%0d want=1", ndone);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_pass got=%b want=0", busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; hist_bins = '0; out_ready = 1'b0;
        #1;
        vectors++;
        if ({rd_en, rd_addr, out_valid, out_index, out_count, out_cdf, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {rd_en, rd_addr, out_valid, out_index, out_count, out_cdf, out_last, busy, done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        @(negedge clk);
        hist_bins = 6'd2; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd_en !== 1'b1 || rd_addr !== 6'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle1 got rd_en=%b addr=%0d vld=%b want 1 0 0", rd_en, rd_addr, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (rd_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle2 got rd_en=%b vld=%b want 0 0", rd_en, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 6'd0 || out_count !== mem[0] || out_cdf !== mem[0]) begin
            errors++;
            $display("FAIL lat_cycle3 got vld=%b idx=%0d cnt=%h cdf=%h want 1 0 %h %h",
                     out_valid, out_index, out_count, out_cdf, mem[0], mem[0]);
        end
        @(negedge clk);
        vectors++;
        if (rd_en !== 1'b1 || rd_addr !== 6'd1) begin
            errors++;
            $display("FAIL lat_cycle4 got rd_en=%b addr=%0d want 1 1", rd_en, rd_addr);
        end
        for (int t = 0; t < 50 && !done; t++) @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL lat_done got=%b want=1", done);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
        run_pass(63, 0, 1'b0);
        vectors++;
        if (last_hs_cyc !== 192 || done_cyc !== 193) begin
            errors++;
            $display("FAIL basic_timing got hs=%0d done=%0d want 192 193", last_hs_cyc, done_cyc);
        end
        vectors++;
        if (last_cdf !== 32'd2080) begin
            errors++;
            $display("FAIL basic_final_cdf got=%0d want=2080", last_cdf);
        end
    endtask

    task automatic test_backpressure;
        mem[0] = 32'd10; mem[1] = 32'd20; mem[2] = 32'd30; mem[3] = 32'd40;
        run_pass(3, 1, 1'b0);
        vectors++;
        if (last_cdf !== 32'd100) begin
            errors++;
            $display("FAIL bp_final_cdf got=%0d want=100", last_cdf);
        end
    endtask

    task automatic test_saturation;
        mem[0] = 32'hFFFF_FFF0; mem[1] = 32'h20;
        run_pass(1, 2, 1'b0);
        vectors++;
        if (last_cdf !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_final_cdf got=%h want=ffffffff", last_cdf);
        end
        mem[0] = $urandom;
        run_pass(0, 2, 1'b0);
    endtask

    task automatic test_spurious_start;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = (r == 2) ? ($urandom | 32'h8000_0000) : $urandom_range(0, 1000);
            run_pass($urandom_range(0, 63), 2, 1'b1);
        end
    endtask

    task automatic test_reset_midpass;
        int t;
        for (int i = 0; i < 64; i++) mem[i] = $urandom_range(1, 500);
        @(negedge clk);
        hist_bins = 6'd63; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        while (t < 200 && !(out_valid && out_index == 6'd5)) begin
            @(negedge clk);
            t++;
            out_ready = !(out_valid && out_index == 6'd5);
        end
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midpass_reset got vld=%b busy=%b done=%b rd_en=%b want 0000",
                     out_valid, busy, done, rd_en);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle got done=%b busy=%b want 0 0", done, busy);
            end
        end
        run_pass(63, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_backpressure();
        test_saturation();
        test_spurious_start();
        test_reset_midpass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
